nrs_reg_ctrl: RTL and testbench

NRS_REG_CTRL -- requirements
Module: nrs_reg_ctrl

---
 rtl/nrs_reg_ctrl.sv | 136 +++++++++++++
 tb/tb_nrs_reg_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/nrs_reg_ctrl.sv
// nrs_reg_ctrl
// Sequences one symbol's worth of NRS c_n bits: optionally discards a number
// of leading generator bits, writes NUM_BITS bits into the NRS register as the
// Gold-sequence generator produces them, then serves them in order to the
// channel estimator. One pass per start pulse.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   start        one-cycle request for a fill+serve pass (only honoured in IDLE)
//   skip         number of leading valid generator bits to discard
//   abort        synchronous cancel, highest priority
//   gen_valid    generator presents a valid c_n bit
//   est_ready    estimator consumes the bit at rd_addr_est
//   gen_en       registered run enable to the generator (SKIP/FILL)
//   wr_en        write strobe to the NRS register
//   wr_addr      write bit index
//   rd_addr_est  read bit index
//   est_valid    bit at rd_addr_est is valid
//   busy         high whenever not IDLE
//   done         one-cycle pulse after the last bit is consumed
module nrs_reg_ctrl #(
    parameter int unsigned WIDTH_REG = 16,
    parameter int unsigned LINES     = $clog2(WIDTH_REG),
    parameter int unsigned NUM_BITS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LINES-1:0] skip,
    input  logic             abort,
    input  logic             gen_valid,
    input  logic             est_ready,
    output logic             gen_en,
    output logic             wr_en,
    output logic [LINES-1:0] wr_addr,
    output logic [LINES-1:0] rd_addr_est,
    output logic             est_valid,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SKIP  = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;
    localparam logic [1:0] SERVE = 2'd3;

    localparam logic [LINES-1:0] ZERO = '0;
    localparam logic [LINES-1:0] ONE  = LINES'(1);
    localparam logic [LINES-1:0] LAST = LINES'(NUM_BITS - 1);

    logic [1:0]       state_q, state_d;
    logic [LINES-1:0] skip_cnt_q, skip_cnt_d;
    logic [LINES-1:0] fill_cnt_q, fill_cnt_d;
    logic [LINES-1:0] rd_cnt_q, rd_cnt_d;
    logic             gen_en_q, gen_en_d;
    logic             done_q, done_d;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        fill_cnt_d = fill_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        skip_cnt_d = skip;
                        fill_cnt_d = ZERO;
                        rd_cnt_d   = ZERO;
                        state_d    = (skip != ZERO) ? SKIP : FILL;
                    end
                end
                SKIP: begin
                    if (gen_valid) begin
                        skip_cnt_d = skip_cnt_q - ONE;
                        if (skip_cnt_q == ONE) state_d = FILL;
                    end
                end
                FILL: begin
                    if (gen_valid) begin
                        // Stop at the last index rather than wrapping.
                        if (fill_cnt_q == LAST) state_d = SERVE;
                        else                    fill_cnt_d = fill_cnt_q + ONE;
                    end
                end
                SERVE: begin
                    if (est_ready) begin
                        if (rd_cnt_q == LAST) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            rd_cnt_d = rd_cnt_q + ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Registered enable tracks the state being entered.
        gen_en_d = (state_d == SKIP) || (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            skip_cnt_q <= ZERO;
            fill_cnt_q <= ZERO;
            rd_cnt_q   <= ZERO;
            gen_en_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            fill_cnt_q <= fill_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            gen_en_q   <= gen_en_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        gen_en      = gen_en_q;
        done        = done_q;
        busy        = (state_q != IDLE);
        // Same-edge capture into the register; abort suppresses the write.
        wr_en       = (state_q == FILL) && gen_valid && !abort;
        wr_addr     = (state_q == FILL) ? fill_cnt_q : ZERO;
        est_valid   = (state_q == SERVE);
        rd_addr_est = (state_q == SERVE) ? rd_cnt_q : ZERO;
    end

endmodule

// File: tb/tb_nrs_reg_ctrl.sv
module tb_nrs_reg_ctrl;

    localparam int NB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, gen_valid, est_ready;
    logic [3:0] skip;
    logic       gen_en, wr_en, est_valid, busy, done;
    logic [3:0] wr_addr, rd_addr_est;

    int total = 0;
    int bad   = 0;

    // Behavioural model: a pass is described by how many bits remain to be
    // skipped, how many have been written and how many have been read.
    int m_active, m_skip_left, m_wr, m_rd, m_done;

    // Samples of the last checked cycle.
    logic s_wr_en, s_ev, s_done, s_busy, s_gen_en;
    int   s_wr_addr, s_rd;

    nrs_reg_ctrl #(.WIDTH_REG(16), .LINES(4), .NUM_BITS(NB)) dut (
        .clk(clk), .rst(rst), .start(start), .skip(skip), .abort(abort),
        .gen_valid(gen_valid), .est_ready(est_ready), .gen_en(gen_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr_est(rd_addr_est),
        .est_valid(est_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_skip_left = 0; m_wr = 0; m_rd = 0; m_done = 0;
    endtask

    task automatic step(input logic st, input logic [3:0] sk, input logic ab,
                        input logic gv, input logic er);
        int skipping, filling, serving;
        @(negedge clk);
        start = st; skip = sk; abort = ab; gen_valid = gv; est_ready = er;
        #1;
        skipping = (m_active != 0) && (m_skip_left > 0);
        filling  = (m_active != 0) && (m_skip_left == 0) && (m_wr < NB);
        serving  = (m_active != 0) && (m_wr == NB);
        s_wr_en = wr_en; s_ev = est_valid; s_done = done; s_busy = busy;
        s_gen_en = gen_en; s_wr_addr = int'(wr_addr); s_rd = int'(rd_addr_est);
        chk("wr_en", int'(wr_en), (filling != 0 && gv && !ab) ? 1 : 0);
        chk("wr_addr", int'(wr_addr), filling != 0 ? m_wr : 0);
        chk("est_valid", int'(est_valid), serving);
        chk("rd_addr_est", int'(rd_addr_est), serving != 0 ? m_rd : 0);
        chk("gen_en", int'(gen_en), (skipping != 0 || filling != 0) ? 1 : 0);
        chk("busy", int'(busy), m_active);
        chk("done", int'(done), m_done);
        @(posedge clk);
        m_done = 0;
        if (ab) begin
            m_active = 0;
        end else if (m_active == 0) begin
            if (st) begin
                m_active = 1; m_skip_left = int'(sk); m_wr = 0; m_rd = 0;
            end
        end else if (skipping != 0) begin
            if (gv) m_skip_left--;
        end else if (filling != 0) begin
            if (gv) m_wr++;
        end else if (er) begin
            m_rd++;
            if (m_rd == NB) begin
                m_active = 0;
                m_done = 1;
            end
        end
    endtask

    initial begin
        int k, first_wr, dones, vbeat, ndone;
        start = 0; skip = 0; abort = 0; gen_valid = 0; est_ready = 0;
        rst = 1'b0;
        model_reset();
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_gen_en", int'(gen_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_est_valid", int'(est_valid), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b1;

        // Back-to-back pass: done lands 33 cycles after the start cycle.
        step(1, 0, 0, 1, 1);
        ndone = 0; dones = 0;
        for (k = 1; k <= 40; k++) begin
            step(0, 0, 0, 1, 1);
            if (k <= NB) begin
                chk("b2b_wr_addr", s_wr_addr, k - 1);
                chk("b2b_wr_en", int'(s_wr_en), 1);
            end else if (k <= 2 * NB) begin
                chk("b2b_rd_addr", s_rd, k - NB - 1);
            end
            if (s_done) begin
                dones++;
                if (ndone == 0) ndone = k;
            end
        end
        chk("b2b_done_cycle", ndone, 33);
        chk("b2b_done_count", dones, 1);

        // skip=3 with toggling gen_valid: 4th valid beat writes address 0.
        step(1, 3, 0, 0, 0);
        first_wr = -1; vbeat = 0;
        for (k = 0; k < 8; k++) begin
            step(0, 0, 0, (k % 2 == 0), 0);
            if (k % 2 == 0) vbeat++;
            if (s_wr_en && first_wr < 0) begin
                first_wr = vbeat;
                chk("skip_first_addr", s_wr_addr, 0);
            end
        end
        chk("skip_first_beat", first_wr, 4);
        while (m_active != 0) step(0, 0, 0, 1, 1);

        // Estimator stall at rd_cnt=7, then a start pulse during FILL at 9.
        step(1, 0, 0, 1, 0);
        dones = 0;
        for (k = 0; k < 200 && m_active != 0; k++) begin
            if (m_wr == 9 && m_skip_left == 0) begin
                step(1, 0, 0, 1, 0);
            end else if (m_wr == NB && m_rd == 7) begin
                for (int j = 0; j < 5; j++) begin
                    step(0, 0, 0, 1, 0);
                    chk("stall_addr", s_rd, 7);
                    chk("stall_valid", int'(s_ev), 1);
                end
                step(0, 0, 0, 1, 1);
                step(0, 0, 0, 1, 1);
                chk("stall_resume", s_rd, 8);
            end else begin
                step(0, 0, 0, 1, 1);
            end
            if (s_done) dones++;
        end
        step(0, 0, 0, 0, 0);
        if (s_done) dones++;
        chk("mid_start_done_count", dones, 1);

        // Abort at fill_cnt=5, then a clean restart.
        step(1, 0, 0, 1, 1);
        for (k = 0; k < 5; k++) step(0, 0, 0, 1, 1);
        step(0, 0, 1, 1, 1);
        chk("abort_wr_en", int'(s_wr_en), 0);
        step(0, 0, 0, 1, 1);
        chk("abort_busy", int'(s_busy), 0);
        chk("abort_gen_en", int'(s_gen_en), 0);
        chk("abort_done", int'(s_done), 0);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("restart_addr", s_wr_addr, 0);
        chk("restart_wr_en", int'(s_wr_en), 1);

        // Asynchronous reset in the middle of SERVE.
        for (k = 0; k < 100 && !(m_wr == NB && m_rd == 4); k++) step(0, 0, 0, 1, 1);
        chk("serve_reached", m_rd, 4);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_est_valid", int'(est_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_gen_en", int'(gen_en), 0);
        chk("arst_rd_addr", int'(rd_addr_est), 0);
        chk("arst_wr_en", int'(wr_en), 0);
        chk("arst_done", int'(done), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (k = 0; k < 4; k++) step(0, 0, 0, 1, 1);

        // Randomized traffic against the model.
        for (k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 63) == 0), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
